unified_cache_mem_scheduler: RTL
================================

Name: unified_cache_mem_scheduler

Overview:
- Shares the single cache-to-memory port between the miss and writeback request outputs of all cache banks.
- Each cycle it selects one pending request using critical-first, then round-robin, with an age-based anti-starvation promotion.
- The selected packet is captured into an output register that is held until memory acknowledges it.
- It replaces the fixed-priority to-memory arbiter between the banks and the memory interface.

Parameters:
- NUM_BANK, 4, number of cache banks; there are 2*NUM_BANK request sources.
- UNIFIED_CACHE_PACKET_WIDTH_IN_BITS, `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS, packet width.
- STARVE_THRESHOLD, 15, cycles a valid source may wait before it is promoted to critical; must be at least 1.
- AGE_WIDTH, $clog2(STARVE_THRESHOLD+1), width of each age counter.

Ports:
- clk_in  input  1  clock
- reset_in  input  1  asynchronous active-high reset
- request_flatted_in  input  2*NUM_BANK*PKT  {miss[NUM_BANK-1:0], writeback[NUM_BANK-1:0]}; source i occupies bits [(i+1)*PKT-1 : i*PKT]
- request_valid_flatted_in  input  2*NUM_BANK  per-source valid
- request_critical_flatted_in  input  2*NUM_BANK  per-source critical
- issue_ack_out  output  2*NUM_BANK  one-hot grant pulse
- to_mem_packet_out  output  PKT  held packet; all zeros when empty
- to_mem_packet_valid_out  output  1  output register occupied
- to_mem_packet_ack_in  input  1  memory accepted the held packet
- last_grant_out  output  $clog2(2*NUM_BANK)  index of the most recent grant

Behaviour:
- Reset (asynchronous, active-high):
  - issue_ack_out = 0, to_mem_packet_out = 0, to_mem_packet_valid_out = 0.
  - last_grant_out = 2*NUM_BANK-1, so the first search starts at source 0.
  - All age counters = 0.
  - Reset during operation drops any held packet; no ack is issued in the reset cycle.
- Load condition: load = !to_mem_packet_valid_out || to_mem_packet_ack_in. Back-to-back packets are allowed at 1 per cycle.
- Effective critical: eff_crit[i] = valid[i] && (critical[i] || age[i] == STARVE_THRESHOLD).
- Selection (combinational), evaluated only when load = 1:
  - If any eff_crit bit is set, candidates = eff_crit; otherwise candidates = valid.
  - Winner = first candidate found searching indices last_grant_out+1, +2, … modulo 2*NUM_BANK.
  - With no candidate, there is no grant.
- Grant cycle:
  - issue_ack_out[winner] = 1 combinationally in the same cycle; all other bits are 0.
  - At the clock edge: the output register takes request_flatted_in[winner], valid_out = 1, last_grant_out = winner.
  - The source must drop or advance its request in the next cycle.
- Ack without a new grant: at the edge, valid_out = 0 and to_mem_packet_out = 0.
- No load (register full, no ack): the register holds, issue_ack_out = 0, and the output is unchanged. The packet stays stable until acked.
- Age counters, per source, updated at each edge:
  - valid and not granted → increment, saturating at STARVE_THRESHOLD.
  - granted, or not valid → 0.
  - Counters keep advancing while the output is stalled.
- Packet contents are passed through unmodified. to_mem_packet_valid_out equals the packet's valid bit for well-formed inputs.
- A valid source is never left waiting indefinitely: it becomes critical after at most STARVE_THRESHOLD cycles, and round-robin then bounds its wait.
- Latency: a request at cycle t with an empty register appears on to_mem_packet_out at t+1.

Test Plan:
- Reset, then source 2 valid alone → issue_ack_out = 8'b0000_0100 in that cycle; the packet appears next cycle with valid_out = 1 and last_grant_out = 2.
- All 8 sources valid continuously, to_mem_packet_ack_in tied high → grants follow 0,1,2,…,7,0 one per cycle, and each ack is one-hot.
- All sources valid, source 6 critical, last_grant = 6 → source 6 is granted again before sources 7 and 0.
- to_mem_packet_ack_in low for 5 cycles after a grant → no ack pulses, and to_mem_packet_out is stable. When ack rises with source 3 pending, the new packet loads at that same edge.
- STARVE_THRESHOLD = 3, source 0 always critical, source 5 valid → source 5 is granted after its age reaches 3, interleaving with source 0.
- Reset asserted mid-cycle while a packet is held → valid_out drops immediately with no ack. The first grant after reset goes to the lowest-index valid source.

Source files
------------

// File: rtl/unified_cache_mem_scheduler.sv
`default_nettype none

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 32
`endif

// ============================================================================
// Module   : unified_cache_mem_scheduler
// Purpose  : Shares the single cache-to-memory port between the miss and
//            writeback request outputs of every cache bank. Each cycle that
//            the output register can load, one pending source is picked:
//            critical sources first, then round-robin. A source that has
//            waited STARVE_THRESHOLD cycles is treated as critical. The
//            chosen packet is held in an output register until memory
//            acknowledges it.
//
// Ports    : clk_in                      - clock
//            reset_in                    - asynchronous active-high reset
//            request_flatted_in          - {miss[NUM_BANK-1:0], wb[NUM_BANK-1:0]}
//                                          packets, source i at slice i
//            request_valid_flatted_in    - per-source valid
//            request_critical_flatted_in - per-source critical
//            issue_ack_out               - one-hot grant pulse (combinational)
//            to_mem_packet_out           - held packet, zero when empty
//            to_mem_packet_valid_out     - output register occupied
//            to_mem_packet_ack_in        - memory accepted the held packet
//            last_grant_out              - index of the most recent grant
//
// Revision : 1.0 - initial release
// ============================================================================
module unified_cache_mem_scheduler #(
    parameter int NUM_BANK                           = 4,
    parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
    parameter int STARVE_THRESHOLD                   = 15,
    parameter int AGE_WIDTH                          = $clog2(STARVE_THRESHOLD + 1)
) (
    input  logic                                                    clk_in,
    input  logic                                                    reset_in,
    input  logic [2*NUM_BANK*UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] request_flatted_in,
    input  logic [2*NUM_BANK-1:0]                                   request_valid_flatted_in,
    input  logic [2*NUM_BANK-1:0]                                   request_critical_flatted_in,
    output logic [2*NUM_BANK-1:0]                                   issue_ack_out,
    output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0]           to_mem_packet_out,
    output logic                                                    to_mem_packet_valid_out,
    input  logic                                                    to_mem_packet_ack_in,
    output logic [$clog2(2*NUM_BANK)-1:0]                           last_grant_out
);

    localparam int                       c_num_src = 2 * NUM_BANK;
    localparam int                       c_idx_w   = $clog2(c_num_src);
    localparam int                       c_pkt_w   = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
    localparam logic [AGE_WIDTH-1:0]     c_age_max = AGE_WIDTH'(STARVE_THRESHOLD);
    localparam logic [c_idx_w-1:0]       c_last_rst = c_idx_w'(c_num_src - 1);

    logic [c_pkt_w-1:0]   r_packet;
    logic                 r_valid;
    logic [c_idx_w-1:0]   r_last_grant;

    logic [c_num_src-1:0] w_eff_crit;
    logic [c_num_src-1:0] w_cand;
    logic                 w_load;
    logic                 w_found;
    logic [c_idx_w-1:0]   w_winner;
    logic                 w_grant;
    int                   w_idx;

    // ------------------------------------------------------------------------
    // Per-source age counters and effective-critical flags. A source that is
    // valid but not granted ages by one each edge (even while the output is
    // stalled), saturating at the threshold where it is promoted.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < c_num_src; gi++) begin : g_src
            logic [AGE_WIDTH-1:0] r_age;

            assign w_eff_crit[gi] = request_valid_flatted_in[gi] &&
                                    (request_critical_flatted_in[gi] || (r_age == c_age_max));

            always_ff @(posedge clk_in or posedge reset_in) begin
                if (reset_in) begin
                    r_age <= '0;
                end else if (issue_ack_out[gi] || !request_valid_flatted_in[gi]) begin
                    r_age <= '0;
                end else if (r_age != c_age_max) begin
                    r_age <= r_age + AGE_WIDTH'(1);
                end
            end
        end
    endgenerate

    // The register can take a new packet when empty or when its current
    // occupant is being accepted this cycle (back-to-back at full rate).
    assign w_load = !r_valid || to_mem_packet_ack_in;

    // Critical candidates shadow plain valid ones entirely.
    assign w_cand = (|w_eff_crit) ? w_eff_crit : request_valid_flatted_in;

    // Rotating search starting just after the previous winner. The modulo is
    // done by a single conditional subtract so non-power-of-two source counts
    // wrap correctly.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 1; k <= c_num_src; k++) begin
            w_idx = int'(r_last_grant) + k;
            if (w_idx >= c_num_src) begin
                w_idx = w_idx - c_num_src;
            end
            if (!w_found && w_cand[w_idx]) begin
                w_found  = 1'b1;
                w_winner = c_idx_w'(w_idx);
            end
        end
    end

    // No grant while reset is asserted, so a source is never told it was
    // accepted in a cycle whose capture is being discarded.
    assign w_grant = w_load && w_found && !reset_in;

    always_comb begin
        issue_ack_out = '0;
        if (w_grant) begin
            issue_ack_out[w_winner] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_packet     <= '0;
            r_valid      <= 1'b0;
            r_last_grant <= c_last_rst;
        end else if (w_load) begin
            if (w_grant) begin
                r_packet     <= request_flatted_in[w_winner*c_pkt_w +: c_pkt_w];
                r_valid      <= 1'b1;
                r_last_grant <= w_winner;
            end else begin
                r_packet <= '0;
                r_valid  <= 1'b0;
            end
        end
    end

    assign to_mem_packet_out       = r_packet;
    assign to_mem_packet_valid_out = r_valid;
    assign last_grant_out          = r_last_grant;

endmodule

`default_nettype wire
